// File: rtl/i2c_tx_arbiter.sv
// rtl/i2c_tx_arbiter.sv - shares the I2C slave TX byte path among N_REQ requesters (optional macro: I2C_ARB_FIXED_PRIO_EN)
module i2c_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 SCL,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic                 tx_load,
    input  logic                 ack_valid,
    input  logic                 master_ack,
    input  logic                 stop_det,
    output logic [7:0]           data_in,
    output logic                 data_valid,
    output logic [N_REQ-1:0]     grant,
    output logic                 byte_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [7:0]         data_in_n;
    logic               data_valid_n;
    logic [N_REQ-1:0]   grant_n;
    logic               byte_done_n;

    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W:0]     cand;
    logic               burst_more;

`ifdef I2C_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always begins at requester 0.
    assign search_start = '0;
`else
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   next_ptr;

    assign search_start = rr_ptr;
    assign next_ptr     = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
`endif

    // Another byte may follow only while the burst counter is below the limit.
    assign burst_more = (MAX_BURST == 0) || (burst_cnt < BURST_LAST);

    // Selects byte idx out of the packed requester data bus.
    function automatic logic [7:0] byte_of(input logic [IDX_W-1:0] idx,
                                           input logic [8*N_REQ-1:0] bus);
        byte_of = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) byte_of = bus[8*i +: 8];
        end
    endfunction

    // Winner search: first active request at or after search_start, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, search_start} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; stop_det outranks tx_load and ack_valid.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        burst_cnt_n  = burst_cnt;
        data_in_n    = data_in;
        data_valid_n = data_valid;
        grant_n      = grant;
        byte_done_n  = 1'b0;
`ifndef I2C_ARB_FIXED_PRIO_EN
        rr_ptr_n     = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n          = LOAD;
                    owner_n          = win_idx;
                    grant_n          = '0;
                    grant_n[win_idx] = 1'b1;
                    data_in_n        = byte_of(win_idx, req_data);
                    data_valid_n     = 1'b1;
                    burst_cnt_n      = '0;
                end
            end
            LOAD: begin
                if (stop_det) begin
                    state_n      = RELEASE;
                    data_valid_n = 1'b0;
                    grant_n      = '0;
                end else if (tx_load) begin
                    state_n      = WAIT_ACK;
                    data_valid_n = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (stop_det) begin
                    state_n      = RELEASE;
                    data_valid_n = 1'b0;
                    grant_n      = '0;
                end else if (ack_valid) begin
                    byte_done_n = 1'b1;
                    if (master_ack && req[owner] && burst_more) begin
                        state_n      = LOAD;
                        burst_cnt_n  = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
                        data_in_n    = byte_of(owner, req_data);
                        data_valid_n = 1'b1;
                    end else begin
                        state_n      = RELEASE;
                        data_valid_n = 1'b0;
                        grant_n      = '0;
                    end
                end
            end
            RELEASE: begin
                state_n      = IDLE;
                grant_n      = '0;
                data_valid_n = 1'b0;
`ifndef I2C_ARB_FIXED_PRIO_EN
                rr_ptr_n     = next_ptr;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge SCL) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    // Registered outputs, owner and burst bookkeeping.
    always_ff @(posedge SCL) begin
        if (!RST) begin
            owner      <= '0;
            burst_cnt  <= '0;
            data_in    <= 8'h00;
            data_valid <= 1'b0;
            grant      <= '0;
            byte_done  <= 1'b0;
        end else begin
            owner      <= owner_n;
            burst_cnt  <= burst_cnt_n;
            data_in    <= data_in_n;
            data_valid <= data_valid_n;
            grant      <= grant_n;
            byte_done  <= byte_done_n;
        end
    end

`ifndef I2C_ARB_FIXED_PRIO_EN
    // Round-robin pointer, moved only when a grant is released.
    always_ff @(posedge SCL) begin
        if (!RST) rr_ptr <= '0;
        else      rr_ptr <= rr_ptr_n;
    end
`endif

endmodule

// File: tb/tb_i2c_tx_arbiter.sv
// tb/tb_i2c_tx_arbiter.sv - self-checking bench for i2c_tx_arbiter
module tb_i2c_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 3;
    localparam int CNT_W     = 5;
    localparam int IW        = $clog2(N_REQ);

    logic                SCL = 1'b0;
    logic                RST;
    logic [N_REQ-1:0]    req;
    logic [8*N_REQ-1:0]  req_data;
    logic                tx_load;
    logic                ack_valid;
    logic                master_ack;
    logic                stop_det;
    logic [7:0]          data_in;
    logic                data_valid;
    logic [N_REQ-1:0]    grant;
    logic                byte_done;

    int errors = 0;
    int checks = 0;
    int model_rr = 0;

    always #5 SCL = ~SCL;

    i2c_tx_arbiter #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .SCL(SCL), .RST(RST), .req(req), .req_data(req_data),
        .tx_load(tx_load), .ack_valid(ack_valid), .master_ack(master_ack),
        .stop_det(stop_det), .data_in(data_in), .data_valid(data_valid),
        .grant(grant), .byte_done(byte_done)
    );

    task automatic tick;
        @(posedge SCL);
        #1;
    endtask

    function automatic int model_winner(input logic [N_REQ-1:0] r);
        int start;
        int idx;
`ifdef I2C_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = model_rr;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx = (start + k) % N_REQ;
            if (r[IW'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int w);
        logic [N_REQ-1:0] v;
        v = '0;
        v[IW'(w)] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input int w);
        logic [8*N_REQ-1:0] bus;
        bus = req_data;
        return bus[8*w +: 8];
    endfunction

    task automatic model_release(input int w);
        model_rr = (w + 1) % N_REQ;
    endtask

    task automatic wait_grant(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (grant !== '0 && n < 20) begin tick; n++; end
        while (n < 20) begin
            if (grant !== '0) begin ok = 1'b1; break; end
            tick; n++;
        end
    endtask

    task automatic pulse_tx_load;
        tx_load = 1'b1; tick; tx_load = 1'b0;
    endtask

    task automatic pulse_ack(input logic a);
        ack_valid = 1'b1; master_ack = a; tick; ack_valid = 1'b0; master_ack = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0; req = 4'hF; req_data = $urandom;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (grant !== '0 || data_valid !== 1'b0 || data_in !== 8'h00 || byte_done !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: grant=%b dv=%b data=%h bd=%b, want 0/0/00/0",
                         c, grant, data_valid, data_in, byte_done);
            end
        end
        req = '0; RST = 1'b1; model_rr = 0;
        tick;
    endtask

    task automatic test_single;
        logic [7:0] b;
        req_data = $urandom; req_data[23:16] = 8'hA5; b = 8'hA5;
        req = 4'b0100;
        tick;
        checks++;
        if (grant !== 4'b0100 || data_valid !== 1'b1 || data_in !== b) begin
            errors++;
            $display("FAIL single_latency: grant=%b dv=%b data=%h, want 0100/1/%h", grant, data_valid, data_in, b);
        end
        pulse_tx_load;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL single_txload: dv=%b want 0", data_valid);
        end
        pulse_ack(1'b0);
        checks++;
        if (byte_done !== 1'b1) begin
            errors++; $display("FAIL single_byte_done: bd=%b want 1", byte_done);
        end
        req = '0; model_release(2);
        tick;
        checks++;
        if (byte_done !== 1'b0 || grant !== '0) begin
            errors++; $display("FAIL single_release: bd=%b grant=%b want 0/0000", byte_done, grant);
        end
        tick;
    endtask

    task automatic test_round_robin;
        bit ok;
        int w;
        logic [N_REQ-1:0] r;
        for (int it = 0; it < 14; it++) begin
            if (it < 5) r = 4'hF;
            else begin
                r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            end
            req = r; req_data = $urandom;
            w = model_winner(r);
            wait_grant(ok);
            checks++;
            if (!ok || grant !== onehot(w) || data_in !== byte_at(w) || data_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant it%0d req=%b: grant=%b data=%h dv=%b, want %b/%h/1",
                         it, r, grant, data_in, data_valid, onehot(w), byte_at(w));
            end
            pulse_tx_load;
            pulse_ack(1'b0);
            checks++;
            if (byte_done !== 1'b1) begin
                errors++; $display("FAIL rr_byte_done it%0d: bd=%b want 1", it, byte_done);
            end
            model_release(w);
        end
        req = '0; tick; tick;
    endtask

    task automatic test_burst_limit;
        bit ok;
        logic [7:0] exp_b;
        req = 4'b0010; req_data = $urandom;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== 4'b0010) begin
            errors++; $display("FAIL burst_grant: grant=%b want 0010", grant);
        end
        for (int b = 0; b < MAX_BURST; b++) begin
            exp_b = byte_at(1);
            checks++;
            if (data_valid !== 1'b1 || data_in !== exp_b) begin
                errors++; $display("FAIL burst_byte%0d: dv=%b data=%h want 1/%h", b, data_valid, data_in, exp_b);
            end
            pulse_tx_load;
            req_data = $urandom;
            pulse_ack(1'b1);
            checks++;
            if (byte_done !== 1'b1) begin
                errors++; $display("FAIL burst_done%0d: bd=%b want 1", b, byte_done);
            end
            checks++;
            if (data_valid !== ((b < MAX_BURST - 1) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL burst_continue%0d: dv=%b want %0d", b, data_valid, b < MAX_BURST - 1);
            end
        end
        req = '0; tick; tick;
        checks++;
        if (grant !== '0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL burst_release: grant=%b dv=%b want 0000/0", grant, data_valid);
        end
        model_release(1);
    endtask

    task automatic test_req_drop;
        bit ok;
        logic [7:0] b;
        req = 4'b1000; req_data = $urandom;
        wait_grant(ok);
        b = byte_at(3);
        req = '0;
        tick;
        checks++;
        if (!ok || data_valid !== 1'b1 || data_in !== b || grant !== 4'b1000) begin
            errors++; $display("FAIL drop_hold: grant=%b dv=%b data=%h want 1000/1/%h", grant, data_valid, data_in, b);
        end
        pulse_ack(1'b0);
        checks++;
        if (byte_done !== 1'b0 || data_valid !== 1'b1) begin
            errors++; $display("FAIL ack_in_load: bd=%b dv=%b want 0/1", byte_done, data_valid);
        end
        pulse_tx_load;
        pulse_ack(1'b1);
        checks++;
        if (byte_done !== 1'b1 || data_valid !== 1'b0) begin
            errors++; $display("FAIL drop_release: bd=%b dv=%b want 1/0", byte_done, data_valid);
        end
        tick;
        checks++;
        if (grant !== '0) begin
            errors++; $display("FAIL drop_grant: grant=%b want 0000", grant);
        end
        model_release(3);
        tick;
    endtask

    task automatic test_stop;
        bit ok;
        int w;
        logic [N_REQ-1:0] r;
        r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        req = r; req_data = $urandom; w = model_winner(r);
        wait_grant(ok);
        checks++;
        if (!ok || grant !== onehot(w)) begin
            errors++; $display("FAIL stop_grant: grant=%b want %b", grant, onehot(w));
        end
        pulse_tx_load;
        stop_det = 1'b1; ack_valid = 1'b1; master_ack = 1'b1;
        tick;
        stop_det = 1'b0; ack_valid = 1'b0; master_ack = 1'b0; req = '0;
        checks++;
        if (byte_done !== 1'b0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL stop_wait_ack: bd=%b dv=%b want 0/0", byte_done, data_valid);
        end
        tick;
        checks++;
        if (grant !== '0 || byte_done !== 1'b0) begin
            errors++; $display("FAIL stop_idle: grant=%b bd=%b want 0000/0", grant, byte_done);
        end
        model_release(w);
        r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        req = r; req_data = $urandom; w = model_winner(r);
        wait_grant(ok);
        checks++;
        if (!ok || grant !== onehot(w) || data_valid !== 1'b1) begin
            errors++; $display("FAIL stop2_grant: grant=%b dv=%b want %b/1", grant, data_valid, onehot(w));
        end
        stop_det = 1'b1; tx_load = 1'b1;
        tick;
        stop_det = 1'b0; tx_load = 1'b0; req = '0;
        checks++;
        if (data_valid !== 1'b0 || byte_done !== 1'b0) begin
            errors++; $display("FAIL stop_load: dv=%b bd=%b want 0/0", data_valid, byte_done);
        end
        pulse_ack(1'b0);
        checks++;
        if (byte_done !== 1'b0 || grant !== '0) begin
            errors++; $display("FAIL stop_ack_ignored: bd=%b grant=%b want 0/0000", byte_done, grant);
        end
        model_release(w);
        tick;
    endtask

    task automatic test_reset_mid_load;
        bit ok;
        req = 4'b0100; req_data = $urandom;
        wait_grant(ok);
        pulse_tx_load;
        pulse_ack(1'b0);
        model_release(2);
        wait_grant(ok);
        checks++;
        if (!ok || data_valid !== 1'b1 || grant !== 4'b0100) begin
            errors++; $display("FAIL rst_pre: grant=%b dv=%b want 0100/1", grant, data_valid);
        end
        RST = 1'b0;
        tick;
        checks++;
        if (data_valid !== 1'b0 || grant !== '0 || data_in !== 8'h00 || byte_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_load: grant=%b dv=%b data=%h bd=%b want 0/0/00/0",
                               grant, data_valid, data_in, byte_done);
        end
        RST = 1'b1; model_rr = 0;
        req = 4'hF; req_data = $urandom;
        wait_grant(ok);
        checks++;
        if (!ok || grant !== onehot(model_winner(4'hF)) || data_in !== byte_at(0)) begin
            errors++; $display("FAIL rst_rearb: grant=%b data=%h want %b/%h",
                               grant, data_in, onehot(model_winner(4'hF)), byte_at(0));
        end
        pulse_tx_load;
        pulse_ack(1'b0);
        req = '0;
        tick; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; req = '0; req_data = '0; tx_load = 1'b0;
        ack_valid = 1'b0; master_ack = 1'b0; stop_det = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_burst_limit;
        test_req_drop;
        test_stop;
        test_reset_mid_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
